// File: rtl/ysyx_22040759_rw_arbiter_pkg.sv
// ysyx_22040759_rw_arbiter_pkg
// Shared encodings for the rw arbiter: request kinds, AXI response codes,
// transfer size codes and the arbiter FSM states. Also a helper that gives
// the width of a channel index, which stays at least one bit wide for N_CH=1.
package ysyx_22040759_rw_arbiter_pkg;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22040759_rw_arbiter_rr_picker.sv
// ysyx_22040759_rr_picker
// Combinational grant selection for the rw arbiter.
//   valid     in   N_CH    per-channel request valid
//   rr_ptr    in   PTR_W   channel where the round-robin search starts
//   grant     out  N_CH    one-hot grant (zero when nothing is valid)
//   idx       out  PTR_W   index of the granted channel
//   any_valid out  1       at least one channel is requesting
// Policy macro: RW_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, rr_ptr ignored); the default build searches from rr_ptr upward and
// wraps from N_CH-1 to 0.
module ysyx_22040759_rr_picker
  import ysyx_22040759_rw_arbiter_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int PTR_W = ptr_width(N_CH)
) (
  input  logic [N_CH-1:0]  valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_CH-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             any_valid
);

`ifdef RW_ARB_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = |valid;
    // Scan downward so the lowest valid index is the last one written.
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (valid[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = PTR_W'(c);
      end
    end
  end
`else
  logic found;
  int   chan;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = |valid;
    found     = 1'b0;
    chan      = 0;
    for (int k = 0; k < N_CH; k++) begin
      chan = (int'(rr_ptr) + k) % N_CH;
      if (!found && valid[chan]) begin
        found       = 1'b1;
        grant[chan] = 1'b1;
        idx         = PTR_W'(chan);
      end
    end
  end
`endif

endmodule

// File: rtl/ysyx_22040759_rw_arbiter.sv
// ysyx_22040759_rw_arbiter
// Shares the AXI bridge's single rw port between N_CH requesters. One
// transaction is in flight at a time; the request is captured at grant and
// the response is returned only to the granted channel.
//   clock, reset          system clock, asynchronous active-high reset
//   s_valid_i/s_ready_o   per-channel request valid / one-cycle done pulse
//   s_req_i/s_addr_i/s_size_i/s_wdata_i  per-channel payload, channel c at
//                         slice c of each packed bus
//   s_rdata_o/s_resp_o    shared response, meaningful with s_ready_o[c]
//   m_*                   bridge side (valid/ready/req/addr/size/wdata/rdata/resp)
// Policy macro: RW_ARB_FIXED_PRIO_EN gives fixed priority with ch0 highest
// and no rotating pointer; default is round-robin.
//
// state    | meaning
// ARB_IDLE | waiting for any s_valid_i; captures the picked request
// ARB_BUSY | m_valid_o high, bridge working on the captured request
// ARB_DONE | s_ready_o pulses for the granted channel, pointer advances
module ysyx_22040759_rw_arbiter
  import ysyx_22040759_rw_arbiter_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          s_valid_i,
  output logic [N_CH-1:0]          s_ready_o,
  input  logic [N_CH-1:0]          s_req_i,
  input  logic [N_CH*ADDR_W-1:0]   s_addr_i,
  input  logic [N_CH*2-1:0]        s_size_i,
  input  logic [N_CH*DATA_W-1:0]   s_wdata_i,
  output logic [DATA_W-1:0]        s_rdata_o,
  output logic [1:0]               s_resp_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     m_req_o,
  output logic [ADDR_W-1:0]        m_addr_o,
  output logic [1:0]               m_size_o,
  output logic [DATA_W-1:0]        m_wdata_o,
  input  logic [DATA_W-1:0]        m_rdata_i,
  input  logic [1:0]               m_resp_i
);

  localparam int PTR_W = ptr_width(N_CH);

  arb_state_e        state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [N_CH-1:0]   gnt_q;
  logic [PTR_W-1:0]  pick_idx;
  logic [N_CH-1:0]   pick_gnt;
  logic              pick_any;
  logic              take_req;
  logic              take_rsp;

  logic              sel_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;

  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        resp_q;

  ysyx_22040759_rr_picker #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid     (s_valid_i),
    .rr_ptr    (rr_ptr),
    .grant     (pick_gnt),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Payload mux driven by the one-hot grant so every slice index is constant.
  always_comb begin
    sel_req   = REQ_READ;
    sel_addr  = '0;
    sel_size  = SIZE_BYTE;
    sel_wdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (pick_gnt[c]) begin
        sel_req   = s_req_i[c];
        sel_addr  = s_addr_i[c*ADDR_W +: ADDR_W];
        sel_size  = s_size_i[c*2 +: 2];
        sel_wdata = s_wdata_i[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_req  = 1'b0;
    take_rsp  = 1'b0;
    m_valid_o = 1'b0;
    s_ready_o = '0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          take_req  = 1'b1;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        m_valid_o = 1'b1;
        if (m_ready_i) begin
          take_rsp  = 1'b1;
          state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: begin
        s_ready_o = gnt_q;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_idx <= '0;
      gnt_q   <= '0;
      req_q   <= REQ_READ;
      addr_q  <= '0;
      size_q  <= SIZE_BYTE;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      if (take_req) begin
        gnt_idx <= pick_idx;
        gnt_q   <= pick_gnt;
        req_q   <= sel_req;
        addr_q  <= sel_addr;
        size_q  <= sel_size;
        wdata_q <= sel_wdata;
      end
      if (take_rsp) begin
        rdata_q <= m_rdata_i;
        resp_q  <= m_resp_i;
      end
    end
  end

`ifdef RW_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == ARB_DONE) begin
      rr_ptr <= (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end
`endif

  assign m_req_o   = req_q;
  assign m_addr_o  = addr_q;
  assign m_size_o  = size_q;
  assign m_wdata_o = wdata_q;
  assign s_rdata_o = rdata_q;
  assign s_resp_o  = resp_q;

endmodule

// File: tb/tb_ysyx_22040759_rw_arbiter.sv
// Directed bench for ysyx_22040759_rw_arbiter: a 2-channel instance carries
// most scenarios, a 3-channel instance covers the wrap-around search.
module tb_ysyx_22040759_rw_arbiter;
  import ysyx_22040759_rw_arbiter_pkg::*;

`ifdef RW_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // 2-channel instance
  logic [1:0]   s_valid, s_req, s_ready;
  logic [127:0] s_addr, s_wdata;
  logic [3:0]   s_size;
  logic [63:0]  s_rdata;
  logic [1:0]   s_resp;
  logic         m_valid, m_ready, m_req;
  logic [63:0]  m_addr, m_wdata, m_rdata;
  logic [1:0]   m_size, m_resp;

  // 3-channel instance
  logic [2:0]   t_valid, t_req, t_ready;
  logic [191:0] t_addr, t_wdata;
  logic [5:0]   t_size;
  logic [63:0]  t_rdata;
  logic [1:0]   t_resp;
  logic         t_m_valid, t_m_ready, t_m_req;
  logic [63:0]  t_m_addr, t_m_wdata, t_m_rdata;
  logic [1:0]   t_m_size, t_m_resp;

  ysyx_22040759_rw_arbiter #(.N_CH(2), .ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_req_i(s_req),
    .s_addr_i(s_addr), .s_size_i(s_size), .s_wdata_i(s_wdata),
    .s_rdata_o(s_rdata), .s_resp_o(s_resp),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_req_o(m_req),
    .m_addr_o(m_addr), .m_size_o(m_size), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata), .m_resp_i(m_resp)
  );

  ysyx_22040759_rw_arbiter #(.N_CH(3), .ADDR_W(64), .DATA_W(64)) dut3 (
    .clock(clock), .reset(reset),
    .s_valid_i(t_valid), .s_ready_o(t_ready), .s_req_i(t_req),
    .s_addr_i(t_addr), .s_size_i(t_size), .s_wdata_i(t_wdata),
    .s_rdata_o(t_rdata), .s_resp_o(t_resp),
    .m_valid_o(t_m_valid), .m_ready_i(t_m_ready), .m_req_o(t_m_req),
    .m_addr_o(t_m_addr), .m_size_o(t_m_size), .m_wdata_o(t_m_wdata),
    .m_rdata_i(t_m_rdata), .m_resp_i(t_m_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Bridge: hold off lat cycles (checking m_valid stays up), then one ready pulse.
  task automatic serve(input int lat, input logic [63:0] rd, input logic [1:0] rsp);
    for (int i = 0; i < lat; i++) begin
      chk("busy_valid_held", 64'(m_valid), 64'd1);
      tick();
    end
    m_ready = 1'b1;
    m_rdata = rd;
    m_resp  = rsp;
    tick();
    m_ready = 1'b0;
    m_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    m_resp  = 2'b11;
  endtask

  // s_ready must be one-hot or zero on every cycle.
  always @(negedge clock) begin
    if (!reset) begin
      chk("onehot_n2", 64'($onehot0(s_ready)), 64'd1);
      chk("onehot_n3", 64'($onehot0(t_ready)), 64'd1);
    end
  end

  initial begin
    s_valid = '0; s_req = '0; s_addr = '0; s_wdata = '0; s_size = '0;
    m_ready = 1'b0; m_rdata = '0; m_resp = '0;
    t_valid = '0; t_req = '0; t_addr = '0; t_wdata = '0; t_size = '0;
    t_m_ready = 1'b0; t_m_rdata = '0; t_m_resp = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_s_rdata", s_rdata, 64'd0);
    chk("rst_t_m_valid", 64'(t_m_valid), 64'd0);
    reset = 1'b0;

    // Single read on ch0, bridge answers 4 cycles after m_valid rises.
    s_valid = 2'b01; s_req[0] = REQ_READ;
    s_addr[63:0] = 64'h8000_0000; s_size[1:0] = 2'b11;
    tick();
    chk("t1_m_valid", 64'(m_valid), 64'd1);
    chk("t1_m_addr", m_addr, 64'h8000_0000);
    chk("t1_m_req", 64'(m_req), 64'd0);
    chk("t1_m_size", 64'(m_size), 64'd3);
    chk("t1_no_early_ready", 64'(s_ready), 64'd0);
    serve(4, 64'h1122_3344_5566_7788, RESP_OKAY);
    chk("t1_s_ready", 64'(s_ready), 64'd1);
    chk("t1_s_rdata", s_rdata, 64'h1122_3344_5566_7788);
    chk("t1_s_resp", 64'(s_resp), 64'd0);
    chk("t1_done_m_valid", 64'(m_valid), 64'd0);
    s_valid = 2'b00;
    tick();
    chk("t1_ready_cleared", 64'(s_ready), 64'd0);
    chk("t1_rdata_held", s_rdata, 64'h1122_3344_5566_7788);
    chk("t1_idle_m_valid", 64'(m_valid), 64'd0);

    // Both channels requesting continuously, from a fresh pointer.
    reset = 1'b1; tick(); reset = 1'b0;
    s_valid = 2'b11; s_req = 2'b00;
    s_addr[63:0] = 64'h1000; s_addr[127:64] = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      int ch;
      ch = FIXED ? 0 : (i % 2);
      tick();
      chk("t2_m_addr", m_addr, (ch == 1) ? 64'h2000 : 64'h1000);
      m_ready = 1'b1; m_rdata = 64'(i + 16); m_resp = RESP_OKAY;
      tick();
      m_ready = 1'b0;
      chk("t2_s_ready", 64'(s_ready), (ch == 1) ? 64'd2 : 64'd1);
      chk("t2_s_rdata", s_rdata, 64'(i + 16));
      tick();
    end
    s_valid = 2'b00;

    // Write on ch1; payload changes after grant must not reach the bridge.
    s_valid = 2'b10; s_req[1] = REQ_WRITE;
    s_addr[127:64] = 64'h8000_0100; s_wdata[127:64] = 64'hDEAD_BEEF;
    s_size[3:2] = 2'b11;
    tick();
    s_req[1] = REQ_READ; s_addr[127:64] = '0;
    s_wdata[127:64] = '1; s_size[3:2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("t3_m_valid", 64'(m_valid), 64'd1);
      chk("t3_m_req", 64'(m_req), 64'(REQ_WRITE));
      chk("t3_m_addr", m_addr, 64'h8000_0100);
      chk("t3_m_wdata", m_wdata, 64'hDEAD_BEEF);
      chk("t3_m_size", 64'(m_size), 64'd3);
      tick();
    end
    m_ready = 1'b1; m_rdata = 64'h55; m_resp = RESP_SLVERR;
    tick();
    m_ready = 1'b0;
    chk("t3_s_ready", 64'(s_ready), 64'd2);
    chk("t3_s_resp", 64'(s_resp), 64'(RESP_SLVERR));
    s_valid = 2'b00;
    tick();
    chk("t3_ready_cleared", 64'(s_ready), 64'd0);
    chk("t3_resp_held", 64'(s_resp), 64'(RESP_SLVERR));

    // Stray m_ready while idle is ignored.
    m_ready = 1'b1; m_rdata = 64'h99; m_resp = RESP_EXOKAY;
    tick();
    m_ready = 1'b0;
    chk("t6_s_ready_a", 64'(s_ready), 64'd0);
    chk("t6_m_valid_a", 64'(m_valid), 64'd0);
    tick();
    chk("t6_s_ready_b", 64'(s_ready), 64'd0);
    chk("t6_m_valid_b", 64'(m_valid), 64'd0);
    chk("t6_rdata_held", s_rdata, 64'h55);
    chk("t6_resp_held", 64'(s_resp), 64'(RESP_SLVERR));

    // Reset in the middle of a transaction.
    s_valid = 2'b01; s_req[0] = REQ_READ; s_addr[63:0] = 64'h8000_0040;
    tick();
    chk("t5_busy_m_valid", 64'(m_valid), 64'd1);
    chk("t5_busy_m_addr", m_addr, 64'h8000_0040);
    m_ready = 1'b1; m_rdata = 64'h77;
    reset = 1'b1;
    #1;
    chk("t5_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_s_ready", 64'(s_ready), 64'd0);
    chk("t5_rst_m_addr", m_addr, 64'd0);
    tick();
    chk("t5_rst_edge_m_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_edge_s_ready", 64'(s_ready), 64'd0);
    m_ready = 1'b0;
    reset = 1'b0;
    tick();
    chk("t5_post_m_valid", 64'(m_valid), 64'd1);
    chk("t5_post_m_addr", m_addr, 64'h8000_0040);
    serve(2, 64'hCAFE, RESP_OKAY);
    chk("t5_post_s_ready", 64'(s_ready), 64'd1);
    chk("t5_post_s_rdata", s_rdata, 64'hCAFE);
    s_valid = 2'b00;
    tick();
    chk("t5_post_cleared", 64'(s_ready), 64'd0);

    // Three channels: only ch2 valid from pointer 0, then the search restarts at ch0.
    t_addr[127:64] = 64'h200; t_addr[191:128] = 64'h300;
    t_valid = 3'b100;
    tick();
    chk("t4_m_valid", 64'(t_m_valid), 64'd1);
    chk("t4_wrap_addr", t_m_addr, 64'h300);
    t_m_ready = 1'b1; t_m_rdata = 64'h33;
    tick();
    t_m_ready = 1'b0;
    chk("t4_s_ready_ch2", 64'(t_ready), 64'd4);
    chk("t4_s_rdata", t_rdata, 64'h33);
    t_valid = 3'b110;
    tick();
    tick();
    chk("t4_next_addr", t_m_addr, 64'h200);
    t_m_ready = 1'b1; t_m_rdata = 64'h22;
    tick();
    t_m_ready = 1'b0;
    chk("t4_s_ready_ch1", 64'(t_ready), 64'd2);
    t_valid = 3'b000;
    tick();
    chk("t4_cleared", 64'(t_ready), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
